// File: rtl/ram_sdp_param.sv
// ram_sdp_param
// -------------
// Parametrised simple-dual-port synchronous RAM. It has one write port and one
// read port, each with its own address. A built-in clear sequencer writes zero
// to every location after reset, so the storage array itself needs no reset.
//
// Parameters
//   DATA_WIDTH  word width in bits (1..64)
//   ADDR_WIDTH  address width; DEPTH = 2**ADDR_WIDTH words
//   RDW_MODE    same-address read-during-write: 0 = old data, 1 = new data
//   OUT_REG     0 = single registered output, 1 = extra output pipeline stage
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   wr_en     write strobe          wr_addr  write address   din  write data
//   rd_en     read strobe           rd_addr  read address
//   dout      read data (holds its value between reads)
//   rd_valid  one-cycle pulse per accepted read, aligned with fresh dout
//   busy      high while the clear sequencer runs; port accesses are ignored
module ram_sdp_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    run;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_fire;
  logic                    bypass;
  logic [DATA_WIDTH-1:0]   rd_word;

  // First read-pipeline stage.
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;

  assign run  = (state == RUN);
  assign busy = (state == CLEAR);

  // ---------------------------------------------------------------------------
  // Clear sequencer: DEPTH cycles of CLEAR, one location per cycle. The last
  // location is written on the same edge that enters RUN.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      if (&clr_cnt) begin
        state <= RUN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port mux: the sequencer owns the write port during CLEAR, so port
  // writes are simply not selected until RUN.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = din;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (wr_en) begin
      mem_we    = 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the clear sequencer zeroes it after
  // every reset instead, which keeps it mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port. The array read is combinational and captured in rd_data_q, so
  // a same-address write on the same edge naturally yields the old word.
  // Write-first mode forwards din around the array instead.
  // ---------------------------------------------------------------------------
  assign rd_fire = run && rd_en;
  assign bypass  = (RDW_MODE == 1) && wr_en && (wr_addr == rd_addr);
  assign rd_word = bypass ? din : mem[rd_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= rd_word;
      end
    end
  end

  // Optional second stage: it follows the first stage one cycle later and
  // holds its word while no new read arrives.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          out_data_q <= rd_data_q;
        end
      end
    end

    assign dout     = out_data_q;
    assign rd_valid = out_valid_q;
  end else begin : g_no_out_reg
    assign dout     = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_ram_sdp_param.sv
// Bench for ram_sdp_param. Three instances share clock and reset:
//   u_a0 : 8x16, read-first, OUT_REG=0
//   u_a1 : 8x16, write-first, OUT_REG=1   (same stimulus as u_a0)
//   u_b  : 32x64, read-first, OUT_REG=0
// Expected read words and their due cycle are queued when a read is driven and
// popped by per-instance monitors on the falling edge when rd_valid appears.
module tb_ram_sdp_param;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset;

  logic        a_wr_en, a_rd_en;
  logic [3:0]  a_wr_addr, a_rd_addr;
  logic [7:0]  a_din;
  logic [7:0]  dout0, dout1;
  logic        v0, v1, busy0, busy1;

  logic        b_wr_en, b_rd_en;
  logic [5:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_din;
  logic [31:0] dout2;
  logic        v2, busy2;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [7:0]  model_a [16];
  logic [31:0] model_b [64];

  ram_sdp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(0), .OUT_REG(0)) u_a0 (
    .clk(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .din(a_din),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .dout(dout0), .rd_valid(v0), .busy(busy0)
  );

  ram_sdp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(1), .OUT_REG(1)) u_a1 (
    .clk(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .din(a_din),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .dout(dout1), .rd_valid(v1), .busy(busy1)
  );

  ram_sdp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(0), .OUT_REG(0)) u_b (
    .clk(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .din(b_din),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .dout(dout2), .rd_valid(v2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (v0) begin
      if (q0.size() == 0) chk("spurious_valid_a0", v0, 0);
      else begin
        e = q0.pop_front();
        chk("data_a0", dout0, e.data);
        chk("due_a0", cyc, e.due);
      end
    end
    if (q0.size() > 0 && q0[0].due < cyc) begin
      chk("missing_valid_a0", v0, 1);
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (v1) begin
      if (q1.size() == 0) chk("spurious_valid_a1", v1, 0);
      else begin
        e = q1.pop_front();
        chk("data_a1", dout1, e.data);
        chk("due_a1", cyc, e.due);
      end
    end
    if (q1.size() > 0 && q1[0].due < cyc) begin
      chk("missing_valid_a1", v1, 1);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (v2) begin
      if (q2.size() == 0) chk("spurious_valid_b", v2, 0);
      else begin
        e = q2.pop_front();
        chk("data_b", dout2, e.data);
        chk("due_b", cyc, e.due);
      end
    end
    if (q2.size() > 0 && q2[0].due < cyc) begin
      chk("missing_valid_b", v2, 1);
      void'(q2.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the 8-bit pair; queues expectations from the reference model.
  task automatic drive_a(input bit we, input logic [3:0] wa, input logic [7:0] d,
                         input bit re, input logic [3:0] ra);
    exp_t e;
    a_wr_en = we; a_wr_addr = wa; a_din = d;
    a_rd_en = re; a_rd_addr = ra;
    if (re) begin
      e.data = 64'(model_a[ra]);
      e.due  = cyc + 1;
      q0.push_back(e);
      e.data = (we && wa == ra) ? 64'(d) : 64'(model_a[ra]);
      e.due  = cyc + 2;
      q1.push_back(e);
    end
    if (we) model_a[wa] = d;
    step();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
  endtask

  task automatic drive_b(input bit we, input logic [5:0] wa, input logic [31:0] d,
                         input bit re, input logic [5:0] ra);
    exp_t e;
    b_wr_en = we; b_wr_addr = wa; b_din = d;
    b_rd_en = re; b_rd_addr = ra;
    if (re) begin
      e.data = 64'(model_b[ra]);
      e.due  = cyc + 1;
      q2.push_back(e);
    end
    if (we) model_b[wa] = d;
    step();
    b_wr_en = 1'b0; b_rd_en = 1'b0;
  endtask

  // Counts edges after reset release until each busy drops. Port inputs of an
  // instance are parked once it reaches RUN so held strobes do not write.
  task automatic wait_clear();
    int na, n1, nb;
    na = 0; n1 = 0; nb = 0;
    for (int i = 1; i <= 100 && (na == 0 || n1 == 0 || nb == 0); i++) begin
      step();
      if (na == 0 && !busy0) begin na = i; a_wr_en = 1'b0; a_rd_en = 1'b0; end
      if (n1 == 0 && !busy1) n1 = i;
      if (nb == 0 && !busy2) begin nb = i; b_wr_en = 1'b0; b_rd_en = 1'b0; end
    end
    chk("clear_len_a0", na, 16);
    chk("clear_len_a1", n1, 16);
    chk("clear_len_b", nb, 64);
    for (int i = 0; i < 16; i++) model_a[i] = '0;
    for (int i = 0; i < 64; i++) model_b[i] = '0;
  endtask

  // Inputs hammer both ports while reset/clear is in progress.
  task automatic hammer_inputs();
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_din = 8'hAA;
    a_rd_en = 1'b1; a_rd_addr = 4'd3;
    b_wr_en = 1'b1; b_wr_addr = 6'd63; b_din = 32'hAAAA_AAAA;
    b_rd_en = 1'b1; b_rd_addr = 6'd63;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    hammer_inputs();
    step();
    step();
    chk("rst_busy_a0", busy0, 1);
    chk("rst_busy_b", busy2, 1);
    chk("rst_dout_a1", dout1, 0);
    chk("rst_valid_a1", v1, 0);
    reset = 1'b1;
    wait_clear();
    chk("post_clear_dout_a0", dout0, 0);
    chk("post_clear_dout_a1", dout1, 0);

    // Clear zeroed everything, and the held wr_en did not write.
    for (int i = 0; i < 16; i++) drive_a(0, 4'd0, 8'd0, 1, 4'(i));

    // Fill, then back-to-back read-back.
    for (int i = 0; i < 16; i++) drive_a(1, 4'(i), 8'(i + 1), 0, 4'd0);
    for (int i = 0; i < 16; i++) drive_a(0, 4'd0, 8'd0, 1, 4'(i));

    // Same-address collision, then the follow-up read.
    drive_a(1, 4'd5, 8'h11, 0, 4'd0);
    drive_a(1, 4'd5, 8'h22, 1, 4'd5);
    drive_a(0, 4'd0, 8'h00, 1, 4'd5);

    // Write-then-read next cycle; write and read of different addresses.
    drive_a(1, 4'd9, 8'h5A, 0, 4'd0);
    drive_a(0, 4'd0, 8'h00, 1, 4'd9);
    drive_a(1, 4'd12, 8'hC3, 1, 4'd4);
    drive_a(0, 4'd0, 8'h00, 1, 4'd12);

    // Hold: dout keeps the last word while rd_en stays low.
    drive_a(1, 4'd7, 8'h33, 0, 4'd0);
    drive_a(0, 4'd0, 8'h00, 1, 4'd7);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("hold_dout_a0", dout0, 8'h33);
      chk("hold_dout_a1", dout1, 8'h33);
      chk("hold_valid_a0", v0, 0);
      chk("hold_valid_a1", v1, 0);
      step();
    end

    // Wide/deep instance.
    drive_b(1, 6'd63, 32'hDEAD_BEEF, 0, 6'd0);
    drive_b(0, 6'd0, 32'h0, 1, 6'd63);
    drive_b(1, 6'd10, 32'h1234_5678, 1, 6'd10);
    drive_b(0, 6'd0, 32'h0, 1, 6'd10);
    drive_b(0, 6'd0, 32'h0, 1, 6'd0);
    step();

    // Reset in the middle of a read burst.
    for (int i = 0; i < 6; i++) drive_a(0, 4'd0, 8'd0, 1, 4'(i));
    a_rd_en = 1'b1; a_rd_addr = 4'd6;
    #3;
    reset = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    chk("midrst_dout_a0", dout0, 0);
    chk("midrst_valid_a0", v0, 0);
    chk("midrst_busy_a0", busy0, 1);
    chk("midrst_dout_a1", dout1, 0);
    chk("midrst_valid_a1", v1, 0);
    chk("midrst_busy_a1", busy1, 1);
    chk("midrst_dout_b", dout2, 0);
    chk("midrst_busy_b", busy2, 1);
    hammer_inputs();
    step();
    step();
    reset = 1'b1;
    wait_clear();

    for (int i = 0; i < 16; i++) drive_a(0, 4'd0, 8'd0, 1, 4'(i));
    drive_b(0, 6'd0, 32'h0, 1, 6'd63);
    drive_b(0, 6'd0, 32'h0, 1, 6'd10);

    // Let the pipelines drain; every queued read must have been seen.
    repeat (4) step();
    chk("drain_a0", q0.size(), 0);
    chk("drain_a1", q1.size(), 0);
    chk("drain_b", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_sdp_param.md
# ram_sdp_param

Parametrised simple-dual-port synchronous RAM that succeeds the fixed 16x8 RAM. Width, depth, read-during-write policy and output pipelining are selectable. It has independent write and read addresses and a read-valid strobe. A built-in clear sequencer zeroes every location after reset. It serves as the generic storage macro for buffers and lookup tables in the datapath.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits (1..64)
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
- RDW_MODE, 0, same-address read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- OUT_REG, 0, 0 = single registered output; 1 = one additional output pipeline stage

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_WIDTH  write address
- din  input  DATA_WIDTH  write data
- rd_en  input  1  read strobe
- rd_addr  input  ADDR_WIDTH  read address
- dout  output  DATA_WIDTH  read data
- rd_valid  output  1  one-cycle pulse marking dout as fresh read data
- busy  output  1  high while the clear sequencer runs; all accesses are ignored

## Operation
- FSM states: CLEAR and RUN.
- Reset asserted (reset=0), asynchronously:
  - state=CLEAR, clear counter=0, busy=1
  - dout=0, rd_valid=0, all pipeline registers=0
- CLEAR, after reset deasserts:
  - Writes 0 to location counter each cycle and increments the counter.
  - When the counter reaches DEPTH-1, that write completes and the state moves to RUN the same edge.
  - CLEAR lasts exactly DEPTH cycles; busy drops on the edge that enters RUN.
- CLEAR accesses:
  - wr_en and rd_en are ignored; there is no memory write from the port.
  - rd_valid stays 0 and dout stays 0.
- RUN, write: wr_en=1 writes din to mem[wr_addr] on the rising edge.
- RUN, read: rd_en=1 samples mem[rd_addr] into the read register.
- Write and read in the same cycle to different addresses are independent.
- Same address, RDW_MODE=0: dout returns the pre-write contents; the new data is visible to later reads.
- Same address, RDW_MODE=1: dout returns din of that cycle (bypass).
- rd_en=0: dout holds its last value and rd_valid=0.
- Address wrap: addresses are taken modulo DEPTH; there is no out-of-range case.
- Reset mid-operation, in any state: immediate return to CLEAR, and the full clear repeats. The in-flight read is dropped: rd_valid=0 and dout=0.

## Timing
- Read latency, measured from the edge sampling rd_en=1:
  - OUT_REG=0: dout/rd_valid update on that same edge, visible for the following cycle (1-cycle latency).
  - OUT_REG=1: update one edge later (2-cycle latency).
- rd_valid is high exactly one cycle per accepted read. Back-to-back reads give back-to-back valid pulses, sustaining throughput of 1 read plus 1 write per cycle.
- Write-then-read of the same address in consecutive cycles always returns the new data, independent of RDW_MODE.
- busy is high from reset assertion through DEPTH clock edges after deassertion.

## Test plan
- Reset and clear (DATA_WIDTH=8, ADDR_WIDTH=4):
  - Pulse reset low, release, hold wr_en=1 with din=8'hAA.
  - Expect busy=1 for exactly 16 cycles, then 0.
  - Reads of addresses 0..15 all return 8'h00; no write was accepted.
- Fill and read-back:
  - Write din=addr+1 to addresses 0..15.
  - Read 0..15 back-to-back: dout=1..16 with rd_valid high every cycle.
  - Latency is 1 cycle (OUT_REG=0) and 2 cycles (OUT_REG=1).
- Collision (address 5 holds 8'h11):
  - In one cycle, write 8'h22 to address 5 and read address 5.
  - RDW_MODE=0 gives 8'h11; RDW_MODE=1 gives 8'h22.
  - The next read of address 5 gives 8'h22 in both modes.
- Hold behaviour: after reading 8'h33, drop rd_en for 4 cycles → dout stays 8'h33 and rd_valid=0.
- Mid-operation reset:
  - Assert reset during a read burst → dout=0, rd_valid=0, busy=1 immediately.
  - After release, 16 clear cycles follow, then every location reads 8'h00.
- Width/depth sweep: DATA_WIDTH=32, ADDR_WIDTH=6.
  - Write 32'hDEADBEEF to address 63 → read back gives 32'hDEADBEEF.
  - CLEAR lasts 64 cycles.
